// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
// State encoding, default geometry and word/byte-enable widths live here.
package dmem_responder_pkg;

   localparam int DEF_DEPTH   = 256;
   localparam int DEF_LATENCY = 3;
   localparam int WORD_W      = 32;
   localparam int BE_W        = WORD_W / 8;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit synchronous storage with a byte-write port and a registered read port.
// The read register holds its value until the next read strobe.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter  int DEPTH  = DEF_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [BE_W-1:0]   be_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rdata;

   // NOTE: the array and its read register are deliberately left out of reset so
   // contents survive rst_i and the storage maps onto plain RAM cells.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be_i[b]) r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
      if (re_i) r_rdata <= r_mem[addr_i];
   end

   assign rdata_o = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits LATENCY
// cycles, commits to dmem_array, then holds the response until the CPU takes it.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [31:0]       req_addr_i,
   input  logic [WORD_W-1:0] req_wdata_i,
   input  logic [BE_W-1:0]   req_be_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [WORD_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o
);

   localparam int               ADDR_W     = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
   localparam logic [31:0]      ADDR_LIMIT = 32'(DEPTH * 4);

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;
   logic              r_err;
   logic              r_rd_ok;

   logic              w_accept;
   logic              w_commit;
   logic              w_we;
   logic [31:0]       w_addr;
   logic [WORD_W-1:0] w_wdata;
   logic [BE_W-1:0]   w_be;
   logic              w_err;
   logic [WORD_W-1:0] w_rdata;

   assign req_ready_o = (r_state == ST_IDLE) && !rst_i;
   assign w_accept    = req_valid_i && req_ready_o;

   // With LATENCY=1 the commit coincides with the accept edge, so the port feeds it directly.
   assign w_we    = (r_state == ST_IDLE) ? req_we_i    : r_we;
   assign w_addr  = (r_state == ST_IDLE) ? req_addr_i  : r_addr;
   assign w_wdata = (r_state == ST_IDLE) ? req_wdata_i : r_wdata;
   assign w_be    = (r_state == ST_IDLE) ? req_be_i    : r_be;
   assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr >= ADDR_LIMIT);

   // NOTE: every output of this block gets a default first so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      w_next   = r_state;
      w_commit = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (LATENCY == 1) begin
                  w_next   = ST_RESP;
                  w_commit = 1'b1;
               end else begin
                  w_next = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (r_cnt == '0) begin
               w_next   = ST_RESP;
               w_commit = 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_err   <= 1'b0;
         r_rd_ok <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_be    <= req_be_i;
            r_cnt   <= CNT_LOAD;
         end else if (r_state == ST_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_commit) begin
            r_err   <= w_err;
            r_rd_ok <= !w_we && !w_err;
         end
      end
   end

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (w_commit && w_we && !w_err),
      .re_i    (w_commit && !w_we && !w_err),
      .addr_i  (w_addr[ADDR_W+1:2]),
      .wdata_i (w_wdata),
      .be_i    (w_be),
      .rdata_o (w_rdata)
   );

   assign rsp_valid_o = (r_state == ST_RESP);
   assign rsp_err_o   = rsp_valid_o && r_err;
   assign rsp_rdata_o = (rsp_valid_o && r_rd_ok) ? w_rdata : '0;

endmodule
